// File: rtl/pipe_mux_n.sv
// pipe_mux_n: N-input, WIDTH-bit select stage with a registered output,
// a 2-entry skid buffer, valid/ready flow control and a sticky error flag.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   in_bus         packed inputs, input k at bits [k*WIDTH +: WIDTH]
//   sel            select code, sampled with in_bus on acceptance
//   in_valid       upstream word valid
//   in_ready       stage can accept a word (registered)
//   out_data       selected word (registered)
//   out_idx        index actually used after out-of-range substitution
//   out_valid      out_data valid
//   out_ready      downstream accepts
//   sel_err        sticky: an out-of-range sel was accepted
//   err_clr        clears sel_err (a coincident set wins)
module pipe_mux_n #(
    parameter int WIDTH   = 32,
    parameter int N_IN    = 3,
    parameter int SEL_W   = 2,
    parameter int DEF_IDX = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_IN*WIDTH-1:0]   in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    input  logic                    err_clr
);

    localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEF_IDX);

    // EMPTY: nothing held. ONE: main register holds a word.
    // FULL: main and skid registers both hold words.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   s_data;
    logic [SEL_W-1:0]   s_idx;

    logic               in_range;
    logic [SEL_W-1:0]   new_idx;
    logic [WIDTH-1:0]   new_data;
    logic               acc;
    logic               pop;

    // Zero-extend both sides so the compare is exact; when N_IN fills
    // the whole select space this is constant-true.
    assign in_range = (32'(sel) < 32'(N_IN));
    assign new_idx  = in_range ? sel : DEF_SEL;

    always_comb begin
        new_data = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (new_idx == SEL_W'(k)) begin
                new_data = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign acc = in_valid && in_ready;
    assign pop = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            s_data    <= '0;
            s_idx     <= '0;
            sel_err   <= 1'b0;
        end else begin
            if (acc && !in_range) begin
                sel_err <= 1'b1;
            end else if (err_clr) begin
                sel_err <= 1'b0;
            end

            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        out_data  <= new_data;
                        out_idx   <= new_idx;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        out_data <= new_data;
                        out_idx  <= new_idx;
                    end else if (acc) begin
                        // Downstream stalled: park the new word in skid.
                        s_data   <= new_data;
                        s_idx    <= new_idx;
                        in_ready <= 1'b0;
                        state    <= FULL;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so no accept can coincide.
                    if (pop) begin
                        out_data <= s_data;
                        out_idx  <= s_idx;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    ap_ready_matches_state: assert property (
        @(posedge clk) disable iff (reset)
        in_ready == (state != FULL)
    );

    ap_valid_matches_state: assert property (
        @(posedge clk) disable iff (reset)
        out_valid == (state != EMPTY)
    );

    ap_stable_under_stall: assert property (
        @(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=>
            (reset || ($stable(out_data) && $stable(out_idx) && out_valid))
    );

endmodule

// File: tb/tb_pipe_mux_n.sv
// tb_pipe_mux_n: directed and randomized bench for pipe_mux_n with a
// queue-based scoreboard and an occupancy/error reference model.
module tb_pipe_mux_n;

    localparam int WIDTH   = 32;
    localparam int N_IN    = 3;
    localparam int SEL_W   = 2;
    localparam int DEF_IDX = 0;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] i;
    } item_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]      sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_idx;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sel_err;
    logic                  err_clr;

    pipe_mux_n #(
        .WIDTH   (WIDTH),
        .N_IN    (N_IN),
        .SEL_W   (SEL_W),
        .DEF_IDX (DEF_IDX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_bus    (in_bus),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_pass = 0;
    int    n_acc  = 0;
    item_t q[$];

    logic             exp_err = 1'b0;
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic [SEL_W-1:0] prev_idx;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic item_t model(logic [N_IN*WIDTH-1:0] bus,
                                    logic [SEL_W-1:0] s);
        item_t r;
        int    k;
        k   = (int'(s) < N_IN) ? int'(s) : DEF_IDX;
        r.d = bus[k*WIDTH +: WIDTH];
        r.i = SEL_W'(k);
        return r;
    endfunction

    // Monitor: inputs are driven just after posedge, so at negedge both
    // the handshakes of the coming edge and the outputs are settled.
    always @(negedge clk) begin
        item_t e;
        if (reset) begin
            q.delete();
            exp_err    = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk("sel_err", 64'(sel_err), 64'(exp_err));
            chk("out_valid_occ", 64'(out_valid), 64'(q.size() != 0));
            chk("in_ready_occ", 64'(in_ready), 64'(q.size() < 2));
            if (stall_prev) begin
                chk("stall_data", 64'(out_data), 64'(prev_data));
                chk("stall_idx", 64'(out_idx), 64'(prev_idx));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 64'(1), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("sb_data", 64'(out_data), 64'(e.d));
                    chk("sb_idx", 64'(out_idx), 64'(e.i));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_bus, sel));
                n_acc++;
                if (int'(sel) >= N_IN) exp_err = 1'b1;
                else if (err_clr) exp_err = 1'b0;
            end else if (err_clr) begin
                exp_err = 1'b0;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] words[3];

    initial begin
        int cyc;
        int base;
        words[0] = 32'hAAAA0000;
        words[1] = 32'hBBBB0001;
        words[2] = 32'hCCCC0002;

        reset     = 1'b1;
        in_valid  = 1'b1;
        in_bus    = {words[2], words[1], words[0]};
        sel       = '0;
        out_ready = 1'b1;
        err_clr   = 1'b0;

        // Reset held with in_valid high.
        step();
        step();
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_idx", 64'(out_idx), 64'(0));
        chk("rst_sel_err", 64'(sel_err), 64'(0));
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Back-to-back selects 0, 1, 2.
        step();
        in_valid = 1'b1;
        sel      = 2'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i < 2) sel = SEL_W'(i + 1);
            else in_valid = 1'b0;
            @(negedge clk);
            chk("seq_data", 64'(out_data), 64'(words[i]));
            chk("seq_idx", 64'(out_idx), 64'(i));
            chk("seq_in_ready", 64'(in_ready), 64'(1));
        end

        // Out-of-range select and sticky error.
        step();
        in_valid = 1'b1;
        sel      = 2'd3;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("oor_data", 64'(out_data), 64'(words[0]));
        chk("oor_idx", 64'(out_idx), 64'(0));
        chk("oor_err", 64'(sel_err), 64'(1));
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr", 64'(sel_err), 64'(0));
        step();
        in_valid = 1'b1;
        sel      = 2'd3;
        err_clr  = 1'b1;
        step();
        in_valid = 1'b0;
        err_clr  = 1'b0;
        @(negedge clk);
        chk("err_set_wins", 64'(sel_err), 64'(1));
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Backpressure: three words pushed while stalled.
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd0;
        step();
        sel = 2'd1;
        step();
        sel = 2'd2;
        @(negedge clk);
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_hold", 64'(out_data), 64'(words[0]));
        step();
        step();
        @(negedge clk);
        chk("bp_in_ready2", 64'(in_ready), 64'(0));
        chk("bp_hold2", 64'(out_data), 64'(words[0]));
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_second", 64'(out_data), 64'(words[1]));
        chk("bp_ready_back", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_third", 64'(out_data), 64'(words[2]));
        step();
        step();

        // Reset while FULL discards both buffered words.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd1;
        step();
        sel = 2'd2;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'(0));
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rf_out_valid", 64'(out_valid), 64'(0));
        chk("rf_in_ready", 64'(in_ready), 64'(1));
        step();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel       = 2'd2;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("rf_first", 64'(out_data), 64'(words[2]));
        step();

        // Randomized traffic, 1000 words.
        base = n_acc;
        cyc  = 0;
        while ((n_acc - base) < 1000 && cyc < 20000) begin
            step();
            in_valid  = 1'($urandom_range(1));
            out_ready = 1'($urandom_range(1));
            sel       = SEL_W'($urandom_range(3));
            err_clr   = ($urandom_range(7) == 0);
            in_bus    = {$urandom, $urandom, $urandom};
            cyc++;
        end
        chk("rand_words", 64'((n_acc - base) >= 1000), 64'(1));
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        repeat (5) step();
        @(negedge clk);
        chk("drain", 64'(q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
